// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        if (n > 1) begin
            for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request strictly after rr_ptr, wrapping modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       start;

    // Rotate so the candidate after rr_ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        start = (32'(rr_ptr) + 32'd1) % NREQ;
        dbl   = {req, req};
        rot   = NREQ'(dbl >> start);
        any   = |req;
        idx   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = IW'((start + 32'(k)) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters;
// a grant lasts one burst, ending on req_last or after MAX_BURST beats.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DSIZE-1:0]   req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic [DSIZE-1:0]        fifo_wdata,
    output logic                    fifo_winc,
    input  logic                    fifo_wfull,
    output logic [clog2(NREQ)-1:0]  grant_id,
    output logic                    busy
);

    localparam int unsigned   IW        = clog2(NREQ);
    localparam int unsigned   CW        = clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            pick_any;
    logic [IW-1:0]   pick_idx;
    logic            beat;
    logic            burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any),
        .idx    (pick_idx)
    );

    // Write path: only the granted requester is connected to the FIFO.
    always_comb begin
        req_ready  = '0;
        fifo_wdata = '0;
        fifo_winc  = 1'b0;
        beat       = 1'b0;
        burst_end  = 1'b0;
        if (state_q == ST_GRANT) begin
            req_ready[grant_id_q] = ~fifo_wfull;
            fifo_wdata            = req_data[32'(grant_id_q) * DSIZE +: DSIZE];
            beat                  = req_valid[grant_id_q] & ~fifo_wfull;
            fifo_winc             = beat;
            burst_end             = beat & (req_last[grant_id_q] | (beat_cnt_q == LAST_BEAT));
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
                // Served requester becomes lowest priority for the next pick.
                if (burst_end) begin
                    rr_ptr_d = grant_id_q;
                    state_d  = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= IW'(NREQ - 1);
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter against a transaction-level arbitration model.
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;
    localparam int IW        = 2;
    localparam int DEPTH     = 2048;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [DSIZE-1:0]      fifo_wdata;
    logic                  fifo_winc;
    logic                  fifo_wfull;
    logic [IW-1:0]         grant_id;
    logic                  busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DSIZE     (DSIZE),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wclk       (wclk),
        .wrst       (wrst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_wdata (fifo_wdata),
        .fifo_winc  (fifo_winc),
        .fifo_wfull (fifo_wfull),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    // Per-requester beat queues: {last, data}
    logic [DSIZE:0] mem [NREQ][DEPTH];
    int hd [NREQ];
    int tl [NREQ];

    int p_valid, p_full;
    bit chk_en;
    int n_checks, n_pass, cyc;

    // Reference model: who owns the port, who was served last, beats so far.
    bit m_busy;
    int m_gid, m_last_served, m_beats;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        else
            n_pass++;
    endtask

    task automatic push(input int r, input logic [DSIZE-1:0] d, input logic l);
        if (tl[r] < DEPTH) begin
            mem[r][tl[r]] = {l, d};
            tl[r]++;
        end
    endtask

    task automatic step(input logic rst);
        logic [NREQ-1:0]  exp_rdy;
        logic             exp_winc;
        logic [DSIZE-1:0] exp_wd;
        int               g;
        bit               found;
        @(negedge wclk);
        wrst = rst;
        for (int i = 0; i < NREQ; i++) begin
            if (hd[i] < tl[i] && int'($urandom_range(99)) < p_valid) begin
                req_valid[i]               = 1'b1;
                req_data[i*DSIZE +: DSIZE] = mem[i][hd[i]][DSIZE-1:0];
                req_last[i]                = mem[i][hd[i]][DSIZE];
            end else begin
                req_valid[i]               = 1'b0;
                req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom);
                req_last[i]                = 1'($urandom);
            end
        end
        fifo_wfull = rst ? 1'b1 : (int'($urandom_range(99)) < p_full);
        #1;
        g        = m_gid;
        exp_rdy  = '0;
        exp_winc = 1'b0;
        exp_wd   = '0;
        if (m_busy) begin
            exp_wd = req_data[g*DSIZE +: DSIZE];
            if (!fifo_wfull) begin
                exp_rdy[g] = 1'b1;
                exp_winc   = req_valid[g];
            end
        end
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("grant_id", 32'(grant_id), 32'(g));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("fifo_winc", 32'(fifo_winc), 32'(exp_winc));
            chk("fifo_wdata", 32'(fifo_wdata), 32'(exp_wd));
        end
        // Requesters retire a beat on their own observed handshake.
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i] && hd[i] < tl[i]) hd[i]++;
        if (rst) begin
            m_busy = 0; m_gid = 0; m_last_served = NREQ - 1; m_beats = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
                if (!found && req_valid[(m_last_served + k) % NREQ]) begin
                    found   = 1;
                    m_busy  = 1;
                    m_gid   = (m_last_served + k) % NREQ;
                    m_beats = 0;
                end
            end
        end else if (exp_winc) begin
            m_beats++;
            if (req_last[g] || m_beats == MAX_BURST) begin
                m_busy        = 0;
                m_last_served = g;
            end
        end
        cyc++;
    endtask

    initial begin
        int r, len;
        n_checks = 0; n_pass = 0; cyc = 0; chk_en = 0;
        for (int i = 0; i < NREQ; i++) begin hd[i] = 0; tl[i] = 0; end
        m_busy = 0; m_gid = 0; m_last_served = NREQ - 1; m_beats = 0;
        wrst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; fifo_wfull = 1'b1;
        p_valid = 100; p_full = 0;
        step(1'b1);
        step(1'b1);
        chk_en = 1;
        step(1'b1);

        // Single requester, three beats.
        push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
        repeat (8) step(1'b0);

        // Round robin among 0, 1, 3 with single-beat bursts.
        for (int n = 0; n < 2; n++) begin
            push(0, DSIZE'(8'h00 + n), 1); push(1, DSIZE'(8'h80 + n), 1); push(3, DSIZE'(8'hC0 + n), 1);
        end
        repeat (16) step(1'b0);

        // Burst cap: requester 1 never asserts last.
        for (int n = 0; n < 12; n++) push(1, DSIZE'(8'h10 + n), 0);
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        repeat (24) step(1'b0);

        // Backpressure and valid gaps mid-burst.
        push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1);
        push(3, 8'h30, 0); push(3, 8'h31, 1);
        p_full = 60; p_valid = 50;
        repeat (40) step(1'b0);

        // Reset in the middle of a burst.
        p_full = 0; p_valid = 100;
        push(1, 8'h61, 0); push(1, 8'h62, 0); push(1, 8'h63, 0); push(1, 8'h64, 1);
        push(0, 8'h70, 1);
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (12) step(1'b0);

        // Random traffic with occasional resets.
        repeat (150) begin
            r   = int'($urandom_range(NREQ - 1));
            len = int'($urandom_range(6, 1));
            for (int b = 0; b < len; b++)
                push(r, DSIZE'($urandom), (b == len - 1) && ($urandom_range(3) != 0));
        end
        p_valid = 70; p_full = 30;
        for (int c = 0; c < 2000; c++) step((c == 700 || c == 1400) ? 1'b1 : 1'b0);

        // Drain everything still queued.
        for (int i = 0; i < NREQ; i++) push(i, 8'hEE, 1);
        p_valid = 100; p_full = 0;
        repeat (600) step(1'b0);
        for (int i = 0; i < NREQ; i++) chk("drained", 32'(hd[i]), 32'(tl[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
